// File: rtl/prog_mem_arbiter.sv
// Single-port program RAM arbiter between CPU fetch and host loader, with bounded-unfair priority.
// Optional host write protection while the CPU runs is enabled by defining PROG_ARB_WP_EN.
module prog_mem_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 16,
  parameter int CPU_PRIORITY = 1,
  parameter int MAX_CONSEC   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_valid,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              cpu_run,
  output logic              host_wr_err,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_HOST} state_t;

  localparam logic [3:0] MAX_C   = 4'(MAX_CONSEC);
  localparam bit         CPU_FAV = (CPU_PRIORITY != 0);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic [1:0] rd_tag, rd_tag_next;   // bit0: CPU read in flight, bit1: host read in flight

  logic cpu_req, host_req, contested, fav_owner, force_other;
  logic cpu_grant, host_grant, wr_block;

`ifndef PROG_ARB_WP_EN
  logic unused_cpu_run;
  assign unused_cpu_run = cpu_run;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      rd_tag <= 2'b00;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      rd_tag <= rd_tag_next;
    end
  end

  always_comb begin
    cpu_req   = cpu_re & ~rst;
    host_req  = host_valid & ~rst;
    contested = cpu_req & host_req;
    fav_owner = CPU_FAV ? (state == OWN_CPU) : (state == OWN_HOST);
    // Only a favoured-side run can reach the limit; the other side then gets one forced win.
    force_other = (cnt == MAX_C) && fav_owner;

    if (contested) cpu_grant = CPU_FAV ? ~force_other : force_other;
    else           cpu_grant = cpu_req;
    host_grant = host_req & ~cpu_grant;

    state_next = IDLE;
    if (cpu_grant)       state_next = OWN_CPU;
    else if (host_grant) state_next = OWN_HOST;

    cnt_next = 4'd0;
    if (contested) begin
      if ((cpu_grant && state == OWN_CPU) || (host_grant && state == OWN_HOST))
        cnt_next = cnt + 4'd1;
      else
        cnt_next = 4'd1;
    end

`ifdef PROG_ARB_WP_EN
    wr_block = host_grant & host_wr & cpu_run;
`else
    wr_block = 1'b0;
`endif

    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_grant) begin
      mem_re   = 1'b1;
      mem_addr = cpu_addr;
    end else if (host_grant) begin
      mem_addr = host_addr;
      if (host_wr) begin
        mem_we    = ~wr_block;
        mem_wdata = host_wdata;
      end else begin
        mem_re = 1'b1;
      end
    end

    rd_tag_next = {host_grant & ~host_wr, cpu_grant};

    cpu_stall   = cpu_req & ~cpu_grant;
    host_ready  = host_req & host_grant;
    host_wr_err = wr_block;

    cpu_rvalid  = rd_tag[0] & ~rst;
    host_rvalid = rd_tag[1] & ~rst;
    cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
    host_rdata  = host_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Directed bench for prog_mem_arbiter with a behavioural 1-cycle-latency RAM attached.
// Expected values are hand-derived; write-protect checks follow PROG_ARB_WP_EN.
module tb_prog_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re;
  logic [6:0]  cpu_addr;
  logic        cpu_stall, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        host_valid, host_wr;
  logic [6:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_ready, host_rvalid;
  logic [15:0] host_rdata;
  logic        cpu_run, host_wr_err;
  logic        mem_re, mem_we;
  logic [6:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] ram [128];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prog_mem_arbiter #(.ADDR_W(7), .DATA_W(16), .CPU_PRIORITY(1), .MAX_CONSEC(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_addr(cpu_addr), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_valid(host_valid), .host_wr(host_wr), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ready(host_ready),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .cpu_run(cpu_run), .host_wr_err(host_wr_err),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_re = 1'b0; cpu_addr = '0;
    host_valid = 1'b0; host_wr = 1'b0; host_addr = '0; host_wdata = '0;
  endtask

  task automatic host_write(input logic [6:0] a, input logic [15:0] d);
    host_valid = 1'b1; host_wr = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    chk("hw_ready", host_ready, 1);
    tick();
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1; cpu_run = 1'b0; mem_rdata = '0;
    idle_inputs();
    // Requests during reset are ignored, all outputs stay low
    cpu_re = 1'b1; host_valid = 1'b1; host_addr = 7'd3;
    @(negedge clk);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_ready", host_ready, 0);
    chk("rst_addr", mem_addr, 0);
    tick();
    rst = 1'b0; idle_inputs();
    tick();

    // Host-only write then read back
    host_valid = 1'b1; host_wr = 1'b1; host_addr = 7'd5; host_wdata = 16'h1234;
    @(negedge clk);
    chk("w5_ready", host_ready, 1);
    chk("w5_we", mem_we, 1);
    chk("w5_addr", mem_addr, 5);
    chk("w5_wdata", mem_wdata, 16'h1234);
    tick();
    for (int i = 0; i < 4; i++) host_write(7'(i), 16'hA000 + 16'(i));
    host_write(7'd7, 16'h0707);
    host_write(7'd9, 16'h0909);
    host_valid = 1'b1; host_wr = 1'b0; host_addr = 7'd5;
    @(negedge clk);
    chk("r5_ready", host_ready, 1);
    chk("r5_re", mem_re, 1);
    chk("r5_no_rv_after_wr", host_rvalid, 0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("r5_rvalid", host_rvalid, 1);
    chk("r5_rdata", host_rdata, 16'h1234);
    chk("r5_cpu_rv", cpu_rvalid, 0);
    tick();

    // CPU-only streaming fetch
    for (int i = 0; i < 4; i++) begin
      cpu_re = 1'b1; cpu_addr = 7'(i);
      @(negedge clk);
      chk("cpu_stall", cpu_stall, 0);
      chk("cpu_rvalid", cpu_rvalid, (i > 0) ? 1 : 0);
      if (i > 0) chk("cpu_rdata", cpu_rdata, 16'hA000 + 16'(i - 1));
      tick();
    end
    idle_inputs();
    @(negedge clk);
    chk("cpu_rvalid_last", cpu_rvalid, 1);
    chk("cpu_rdata_last", cpu_rdata, 16'hA003);
    tick();

    // Contention: expect C,C,C,C,H,C,C,C,C,H
    for (int i = 0; i < 10; i++) begin
      cpu_re = 1'b1; cpu_addr = 7'd0;
      host_valid = 1'b1; host_wr = 1'b0; host_addr = 7'd1;
      @(negedge clk);
      chk($sformatf("cont%0d_stall", i), cpu_stall, (i == 4 || i == 9) ? 1 : 0);
      chk($sformatf("cont%0d_ready", i), host_ready, (i == 4 || i == 9) ? 1 : 0);
      tick();
    end
    idle_inputs();
    @(negedge clk);
    chk("cont_host_rv", host_rvalid, 1);
    chk("cont_host_rd", host_rdata, 16'hA001);
    tick();

    // Alternating CPU addr 7 / host addr 9: no data swap
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      if (i % 2 == 0) begin
        cpu_re = 1'b1; cpu_addr = 7'd7;
      end else begin
        host_valid = 1'b1; host_addr = 7'd9;
      end
      @(negedge clk);
      if (i > 0 && i % 2 == 0) begin
        chk("alt_host_rv", host_rvalid, 1);
        chk("alt_host_rd", host_rdata, 16'h0909);
        chk("alt_cpu_rv0", cpu_rvalid, 0);
        chk("alt_cpu_rd0", cpu_rdata, 0);
      end else if (i % 2 == 1) begin
        chk("alt_cpu_rv", cpu_rvalid, 1);
        chk("alt_cpu_rd", cpu_rdata, 16'h0707);
        chk("alt_host_rv0", host_rvalid, 0);
        chk("alt_host_rd0", host_rdata, 0);
      end
      tick();
    end
    idle_inputs();
    tick();

    // Reset asserted while a host read is outstanding
    host_valid = 1'b1; host_wr = 1'b0; host_addr = 7'd5;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rv", host_rvalid, 0);
    chk("mid_rst_ready", host_ready, 0);
    chk("mid_rst_re", mem_re, 0);
    tick();
    rst = 1'b0; idle_inputs();
    @(negedge clk);
    chk("post_rst_rv0", host_rvalid, 0);
    tick();
    @(negedge clk);
    chk("post_rst_rv1", host_rvalid, 0);
    tick();

    // Host write while CPU running
    cpu_run = 1'b1;
    host_valid = 1'b1; host_wr = 1'b1; host_addr = 7'd2; host_wdata = 16'hBEEF;
    @(negedge clk);
    chk("wp_ready", host_ready, 1);
`ifdef PROG_ARB_WP_EN
    chk("wp_err", host_wr_err, 1);
    chk("wp_we", mem_we, 0);
`else
    chk("wp_err", host_wr_err, 0);
    chk("wp_we", mem_we, 1);
`endif
    tick();
    idle_inputs(); cpu_run = 1'b0;
    @(negedge clk);
    chk("wp_err_pulse", host_wr_err, 0);
    tick();
    host_valid = 1'b1; host_wr = 1'b0; host_addr = 7'd2;
    tick();
    idle_inputs();
    @(negedge clk);
    chk("wp_rb_rv", host_rvalid, 1);
`ifdef PROG_ARB_WP_EN
    chk("wp_rb_data", host_rdata, 16'hA002);
`else
    chk("wp_rb_data", host_rdata, 16'hBEEF);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
